tt_um_priority_decoder: RTL and testbench

Companion block to the 16-line priority encoder: a handshaked decoder that turns the encoder's 8-bit index code back into a 16-bit line mask. It accepts codes 0x00–0x0F, and 0xF0 as "no line". It can replace the mask or accumulate into it, and reads the mask out one byte at a time. It sits on the Tiny Tapeout user tile and drives the pin side of loop-back tests against the encoder.

---
 rtl/tt_prio_pkg.sv | 21 ++
 rtl/sync_ff.sv | 21 ++
 rtl/tt_um_priority_decoder.sv | 127 ++++++++++++
 tb/tb_tt_um_priority_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_prio_pkg.sv
// Shared definitions for the 16-line priority encoder/decoder pair.
// Both ends take the line count, "no line" code and FSM encoding from here.
package tt_prio_pkg;

  localparam int NUM_LINES = 16;
  localparam logic [7:0] CODE_NONE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [NUM_LINES-1:0] line_onehot(
    input logic [3:0] idx
  );
    line_onehot = '0;
    line_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchronizer of configurable depth.
// Output is the last flop of a reset-to-zero shift chain.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[DEPTH-2:0], d};
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Handshaked index-code to line-mask decoder for the Tiny Tapeout tile.
// Replaces or accumulates the mask, read out one byte at a time.
module tt_um_priority_decoder
  import tt_prio_pkg::*;
#(
  parameter logic [7:0] NONE_CODE   = CODE_NONE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic stb_s;
  logic clr_s;
  logic mode_s;
  logic hsel_s;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_stb (
    .clk(clk), .rst_n(rst_n), .d(uio_in[0]), .q(stb_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES)) u_clr (
    .clk(clk), .rst_n(rst_n), .d(uio_in[1]), .q(clr_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES)) u_mode (
    .clk(clk), .rst_n(rst_n), .d(uio_in[2]), .q(mode_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES)) u_hsel (
    .clk(clk), .rst_n(rst_n), .d(uio_in[3]), .q(hsel_s)
  );

  state_t state;
  state_t state_n;

  logic [7:0]           code_q;
  logic                 mode_q;
  logic [NUM_LINES-1:0] mask;
  logic [NUM_LINES-1:0] mask_n;
  logic                 err;
  logic                 err_n;
  logic                 empty;
  logic                 empty_n;
  logic                 ack;
  logic                 full;
  logic                 is_line;
  logic                 is_none;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (stb_s) state_n = CAPT;
      CAPT:    state_n = ACK;
      ACK:     if (!stb_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      mode_q <= 1'b0;
    end else if (state == IDLE && stb_s) begin
      code_q <= ui_in;
      mode_q <= mode_s;
    end
  end

  assign is_line = (code_q[7:4] == 4'h0);
  assign is_none = (code_q == NONE_CODE);

  // Clear wins over a decode landing in the same cycle.
  always_comb begin
    mask_n  = mask;
    err_n   = err;
    empty_n = empty;
    if (clr_s) begin
      mask_n  = '0;
      err_n   = 1'b0;
      empty_n = 1'b0;
    end else if (state == CAPT) begin
      unique case (1'b1)
        is_line: begin
          mask_n  = (mode_q ? mask : '0)
                  | line_onehot(code_q[3:0]);
          empty_n = 1'b0;
        end
        is_none: begin
          empty_n = 1'b1;
          if (!mode_q) mask_n = '0;
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      err   <= 1'b0;
      empty <= 1'b0;
    end else begin
      mask  <= mask_n;
      err   <= err_n;
      empty <= empty_n;
    end
  end

  assign ack     = (state == ACK);
  assign full    = &mask;
  assign uo_out  = hsel_s ? mask[15:8] : mask[7:0];
  assign uio_out = {full, empty, err, ack, 4'h0};
  assign uio_oe  = 8'hF0;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Directed bench for tt_um_priority_decoder with a per-cycle
// transaction-level reference and literal spot checks.
module tb_tt_um_priority_decoder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  tt_um_priority_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act,
                        input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: pins delayed two cycles, then a request/decode/ack phase.
  logic [15:0] m_mask  = '0;
  logic        m_err   = 1'b0;
  logic        m_empty = 1'b0;
  int          m_ph    = 0;
  logic [7:0]  m_code  = '0;
  logic        m_mode  = 1'b0;
  logic [1:0]  h_stb   = '0;
  logic [1:0]  h_clr   = '0;
  logic [1:0]  h_mode  = '0;
  logic [1:0]  h_hsel  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mask = '0; m_err = 1'b0; m_empty = 1'b0; m_ph = 0;
      m_code = '0; m_mode = 1'b0;
      h_stb = '0; h_clr = '0; h_mode = '0; h_hsel = '0;
    end else begin
      if (h_clr[1]) begin
        m_mask = '0; m_err = 1'b0; m_empty = 1'b0;
      end else if (m_ph == 1) begin
        if (m_code < 8'd16) begin
          if (!m_mode) m_mask = '0;
          m_mask = m_mask | (16'd1 << m_code[3:0]);
          m_empty = 1'b0;
        end else if (m_code == 8'hF0) begin
          m_empty = 1'b1;
          if (!m_mode) m_mask = '0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_ph == 0 && h_stb[1]) begin
        m_ph = 1; m_code = ui_in; m_mode = h_mode[1];
      end else if (m_ph == 1) begin
        m_ph = 2;
      end else if (m_ph == 2 && !h_stb[1]) begin
        m_ph = 0;
      end
      h_stb  = {h_stb[0],  uio_in[0]};
      h_clr  = {h_clr[0],  uio_in[1]};
      h_mode = {h_mode[0], uio_in[2]};
      h_hsel = {h_hsel[0], uio_in[3]};
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_uo;
    logic [7:0] e_uio;
    if (chk_en) begin
      e_uo  = h_hsel[1] ? m_mask[15:8] : m_mask[7:0];
      e_uio = {m_mask == 16'hFFFF, m_empty, m_err, m_ph == 2, 4'h0};
      check8("model_uo_out", uo_out, e_uo);
      check8("model_uio_out", uio_out, e_uio);
      check8("model_uio_oe", uio_oe, 8'hF0);
    end
  end

  function automatic logic [7:0] encode(input logic [15:0] m);
    encode = 8'hF0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) encode = 8'(i);
  endfunction

  task automatic wait_ack_low();
    int n = 0;
    while (uio_out[4] === 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (uio_out[4] !== 1'b0 || n != 3) begin
      errors++;
      $display("FAIL ack_release: ack=%b after %0d edges, expected 0 after 3",
               uio_out[4], n);
    end
  endtask

  // Called at posedge+1; checks ack rises exactly on the 4th edge.
  task automatic xact(input logic [7:0] code, input logic mode,
                      input bit pulse_clr);
    ui_in     = code;
    uio_in[2] = mode;
    uio_in[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (pulse_clr && k == 1) uio_in[1] = 1'b1;
      if (pulse_clr && k == 2) uio_in[1] = 1'b0;
      check1(k == 4 ? "ack_rise" : "ack_early", uio_out[4], k == 4);
    end
    uio_in[0] = 1'b0;
    wait_ack_low();
  endtask

  task automatic read_mask(output logic [15:0] m);
    uio_in[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1 m[7:0] = uo_out;
    uio_in[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1 m[15:8] = uo_out;
    uio_in[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    uio_in[1] = 1'b1;
    @(posedge clk); #1;
    uio_in[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] in_mask;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check8("reset_uo_out", uo_out, 8'h00);
    check8("reset_uio_out", uio_out, 8'h00);
    check8("reset_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xact(8'h03, 1'b0, 1'b0);
    read_mask(m);
    check16("replace_03", m, 16'h0008);
    check8("replace_03_lo", m[7:0], 8'h08);
    xact(8'h0C, 1'b0, 1'b0);
    read_mask(m);
    check16("replace_0c", m, 16'h1000);
    check8("replace_0c_hi", m[15:8], 8'h10);

    clear();
    for (int i = 0; i < 16; i++) xact(8'(i), 1'b1, 1'b0);
    check1("accum_full", uio_out[7], 1'b1);
    read_mask(m);
    check16("accum_all", m, 16'hFFFF);
    xact(8'hF0, 1'b1, 1'b0);
    check1("accum_none_empty", uio_out[6], 1'b1);
    read_mask(m);
    check16("accum_none_mask", m, 16'hFFFF);

    clear();
    xact(8'h06, 1'b0, 1'b0);
    read_mask(m);
    check16("inv_setup", m, 16'h0040);
    xact(8'h21, 1'b0, 1'b0);
    check1("inv_err", uio_out[5], 1'b1);
    read_mask(m);
    check16("inv_mask_kept", m, 16'h0040);
    xact(8'h05, 1'b0, 1'b0);
    check1("inv_err_sticky", uio_out[5], 1'b1);
    read_mask(m);
    check16("inv_then_valid", m, 16'h0020);

    clear();
    for (int i = 0; i < 8; i++) xact(8'(i), 1'b1, 1'b0);
    read_mask(m);
    check16("simul_setup", m, 16'h00FF);
    xact(8'h09, 1'b1, 1'b1);
    check1("simul_err", uio_out[5], 1'b0);
    check1("simul_empty", uio_out[6], 1'b0);
    read_mask(m);
    check16("simul_mask", m, 16'h0000);

    ui_in = 8'h07; uio_in[2] = 1'b0; uio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 check1("midrst_ack_before", uio_out[4], 1'b1);
    check8("midrst_mask_before", uo_out, 8'h80);
    #2 rst_n = 1'b0;
    #1 check1("midrst_ack_drop", uio_out[4], 1'b0);
    check8("midrst_mask_clear", uo_out, 8'h00);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check1(k == 4 ? "postrst_ack" : "postrst_early", uio_out[4], k == 4);
    end
    uio_in[0] = 1'b0;
    wait_ack_low();
    read_mask(m);
    check16("postrst_mask", m, 16'h0080);

    for (int t = 0; t < 6; t++) begin
      in_mask = 16'd1 << $urandom_range(0, 15);
      xact(encode(in_mask), 1'b0, 1'b0);
      read_mask(m);
      check16("loopback", m, in_mask);
    end
    in_mask = 16'h0000;
    xact(encode(in_mask), 1'b0, 1'b0);
    check1("loopback_zero_empty", uio_out[6], 1'b1);
    read_mask(m);
    check16("loopback_zero", m, 16'h0000);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
